// File: rtl/lbp_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module      : lbp_frame_encoder
// Description : Converts a round-robin stream of signed iEEG samples (one
//               channel per transfer, E channels per frame) into one
//               LBP_LENGTH-bit local-binary-pattern code per channel. Once
//               LBP_LENGTH history frames have been absorbed, every completed
//               frame is presented as a bank of E codes until downstream
//               consumes it with send_next_LBP_in.
// Ports       : clk               - clock, rising edge
//               arst_in           - asynchronous reset, active-high
//               clear_in          - synchronous soft clear (same effect as reset)
//               sample_valid_in   - sample_in carries a sample
//               sample_ready_out  - sample accepted this cycle when valid
//               sample_in         - signed sample for the current channel
//               LBP_codes_out     - channel c code at [c*LBP_LENGTH +: LBP_LENGTH]
//               LBP_valid_out     - LBP_codes_out holds an unconsumed frame
//               send_next_LBP_in  - downstream consumes the presented frame
//               warmup_done_out   - LBP_LENGTH history frames collected
// Revision    : 1.0 - initial release
// ============================================================================
module lbp_frame_encoder #(
    parameter int E          = 64,
    parameter int LBP_LENGTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         arst_in,
    input  logic                         clear_in,
    input  logic                         sample_valid_in,
    output logic                         sample_ready_out,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    output logic [E*LBP_LENGTH-1:0]      LBP_codes_out,
    output logic                         LBP_valid_out,
    input  logic                         send_next_LBP_in,
    output logic                         warmup_done_out
);

    localparam int CH_W = (E > 1) ? $clog2(E) : 1;
    localparam int FD_W = $clog2(LBP_LENGTH + 1);

    localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(E - 1);
    localparam logic [FD_W-1:0] C_FD_FULL = FD_W'(LBP_LENGTH);

    logic [CH_W-1:0]              r_ch_idx;
    logic [FD_W-1:0]              r_frames_done;
    logic signed [DATA_WIDTH-1:0] r_prev [E];
    logic [LBP_LENGTH-1:0]        r_sr   [E];

    logic                         w_accept;
    logic                         w_last_ch;
    logic                         w_full;
    logic                         w_bit;
    logic                         w_frame_end;
    logic                         w_report;
    logic [LBP_LENGTH-1:0]        w_new_sr;
    logic [FD_W-1:0]              w_fd_next;
    logic [E*LBP_LENGTH-1:0]      w_bank;

    assign w_last_ch   = (r_ch_idx == C_LAST_CH);
    assign w_full      = (r_frames_done == C_FD_FULL);

    // Only the last channel of a reportable frame can stall, and only while
    // the output bank is still occupied; depends on registers only.
    assign sample_ready_out = !(w_last_ch && w_full && LBP_valid_out);

    assign w_accept    = sample_valid_in & sample_ready_out;
    assign w_frame_end = w_accept & w_last_ch;
    assign w_report    = w_frame_end & w_full;

    // Both operands are signed, so this is a signed strict comparison.
    assign w_bit       = (sample_in > r_prev[r_ch_idx]);
    assign w_new_sr    = (r_sr[r_ch_idx] << 1) | LBP_LENGTH'(w_bit);

    always_comb begin
        w_fd_next = r_frames_done;
        if (w_frame_end && !w_full) begin
            w_fd_next = r_frames_done + FD_W'(1);
        end
    end

    // Output bank: the last channel is updated in the same cycle the frame
    // ends, so take its freshly shifted value instead of the stored one.
    always_comb begin
        w_bank = '0;
        for (int c = 0; c < E; c++) begin
            w_bank[c*LBP_LENGTH +: LBP_LENGTH] = r_sr[c];
        end
        w_bank[(E-1)*LBP_LENGTH +: LBP_LENGTH] = w_new_sr;
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_ch_idx        <= '0;
            r_frames_done   <= '0;
            LBP_codes_out   <= '0;
            LBP_valid_out   <= 1'b0;
            warmup_done_out <= 1'b0;
            for (int c = 0; c < E; c++) begin
                r_prev[c] <= '0;
                r_sr[c]   <= '0;
            end
        end else if (clear_in) begin
            r_ch_idx        <= '0;
            r_frames_done   <= '0;
            LBP_codes_out   <= '0;
            LBP_valid_out   <= 1'b0;
            warmup_done_out <= 1'b0;
            for (int c = 0; c < E; c++) begin
                r_prev[c] <= '0;
                r_sr[c]   <= '0;
            end
        end else begin
            if (w_accept) begin
                r_ch_idx         <= w_last_ch ? '0 : r_ch_idx + CH_W'(1);
                r_prev[r_ch_idx] <= sample_in;
                // Frame 0 only seeds the previous-sample store.
                if (r_frames_done != '0) begin
                    r_sr[r_ch_idx] <= w_new_sr;
                end
                r_frames_done   <= w_fd_next;
                warmup_done_out <= (w_fd_next == C_FD_FULL);
            end

            // A transfer needs the bank free (ready guarantees it), so it
            // can never coincide with a consume.
            if (w_report) begin
                LBP_codes_out <= w_bank;
                LBP_valid_out <= 1'b1;
            end else if (send_next_LBP_in && LBP_valid_out) begin
                LBP_valid_out <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
